mem_port_arbiter: RTL and testbench

Shares the single external memory bus between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage). It runs a Wishbone-style classic single-beat cycle per request and returns read data with a one-cycle acknowledge. While a request is outstanding it raises per-requester stall requests, which `ctrl` turns into the pipeline `stall` vector. On an exception flush it discards the in-flight instruction fetch.

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one Wishbone-classic bus between instruction fetch and data access.
// Data wins arbitration; a flushed fetch is drained without an acknowledge.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    output logic        stallreq_from_if_o,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        stallreq_from_mem_o,

    input  logic        flush_i,

    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    output logic        bus_fault_o,

    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_D = 2'd1,
        BUS_I = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic        fault_q, fault_d;

    logic        mem_elig, if_elig;
    logic        timeout, done, bad;

    // Handshake: a requester holds req and its fields steady until its
    // one-cycle ack; in the ack cycle the request is stale and not granted.
    assign mem_elig = mem_req_i & ~mem_ack_q;
    assign if_elig  = if_req_i & ~if_ack_q & ~flush_i;

    assign timeout = (cnt_q == CNT_LAST);
    assign done    = bus_ack_i | bus_err_i | timeout;
    assign bad     = bus_err_i | (timeout & ~bus_ack_i);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 8'd1;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        dat_d       = dat_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        fault_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (mem_elig) begin
                    state_d = BUS_D;
                    cyc_d   = 1'b1;
                    we_d    = mem_we_i;
                    sel_d   = mem_sel_i;
                    addr_d  = mem_addr_i;
                    dat_d   = mem_wdata_i;
                end else if (if_elig) begin
                    state_d = BUS_I;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = 4'b1111;
                    addr_d  = if_addr_i;
                    dat_d   = 32'h0;
                end
            end
            BUS_D: begin
                if (done) begin
                    state_d   = IDLE;
                    cyc_d     = 1'b0;
                    mem_ack_d = 1'b1;
                    fault_d   = bad;
                    if (bad) begin
                        mem_rdata_d = 32'h0;
                    end else if (!we_q) begin
                        mem_rdata_d = bus_dat_i;
                    end
                end
            end
            BUS_I: begin
                // A flush arriving with the response simply discards it.
                if (done) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    fault_d = bad;
                    if (!flush_i) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bad ? 32'h0 : bus_dat_i;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                    cnt_d   = 8'd0;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    fault_d = bad;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            addr_q      <= 32'h0;
            dat_q       <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            fault_q     <= fault_d;
        end
    end

    assign if_rdata_o          = if_rdata_q;
    assign if_ack_o            = if_ack_q;
    assign stallreq_from_if_o  = if_req_i & ~if_ack_q;
    assign mem_rdata_o         = mem_rdata_q;
    assign mem_ack_o           = mem_ack_q;
    assign stallreq_from_mem_o = mem_req_i & ~mem_ack_q;

    assign bus_cyc_o   = cyc_q;
    assign bus_stb_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_addr_o  = addr_q;
    assign bus_dat_o   = dat_q;
    assign bus_fault_o = fault_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction timing is predicted
// arithmetically per request and matched against observed bus and ack events.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 4;
    localparam int K_ACK = 0, K_ERR = 1, K_ACKERR = 2, K_NONE = 3;
    localparam int SIDE_N = 0, SIDE_D = 1, SIDE_I = 2;

    logic        clk, rst;
    logic        if_req_i, mem_req_i, mem_we_i, flush_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] if_rdata_o, mem_rdata_o;
    logic        if_ack_o, mem_ack_o, stallreq_from_if_o, stallreq_from_mem_o;
    logic        bus_cyc_o, bus_stb_o, bus_we_o, bus_fault_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o, bus_dat_o, bus_dat_i;
    logic        bus_ack_i, bus_err_i;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_ack_o(if_ack_o), .stallreq_from_if_o(stallreq_from_if_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .mem_ack_o(mem_ack_o), .stallreq_from_mem_o(stallreq_from_mem_o),
        .flush_i(flush_i),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
        .bus_fault_o(bus_fault_o), .dbg_state_o(dbg_state)
    );

    typedef struct {
        int          start;
        int          stop;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] dat;
        bit          chk_dat;
    } bus_exp_t;

    typedef struct {
        int          cyc;
        int          side;
        logic [31:0] data;
        bit          fault;
    } ack_exp_t;

    typedef struct {
        int          kind;
        int          d;
        logic [31:0] data;
    } resp_t;

    bus_exp_t    bus_exp_q[$];
    ack_exp_t    ack_exp_q[$];
    resp_t       resp_q[$];

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc_n = 0;
    bit          mon_en = 0;
    logic        prev_cyc = 1'b0;
    int          cur_end = 0;
    int          bc = 0;
    resp_t       cur_resp;
    logic [31:0] mem_model = 32'h0;
    logic [31:0] if_model = 32'h0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (tests %0d)", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // ---------------- reference rules ----------------
    // Last bus cycle index (0-based) of an unflushed access.
    function automatic int end_bc(input int k, input int d);
        return (k != K_NONE && d <= TIMEOUT - 1) ? d : TIMEOUT - 1;
    endfunction

    function automatic bit is_fault(input int k, input int d, input int e);
        return !(k == K_ACK && d == e);
    endfunction

    function automatic int rand_kind();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return K_ACK;
        if (r == 6) return K_ERR;
        if (r == 7) return K_ACKERR;
        return K_NONE;
    endfunction

    // ---------------- monitor + slave responder ----------------
    always @(negedge clk) begin : mon
        bus_exp_t be;
        ack_exp_t ae;
        logic     start;
        start = bus_cyc_o && !prev_cyc;
        if (mon_en) begin
            check("stall_if", 32'(stallreq_from_if_o), 32'(if_req_i & ~if_ack_o));
            check("stall_mem", 32'(stallreq_from_mem_o), 32'(mem_req_i & ~mem_ack_o));
            check("stb_eq_cyc", 32'(bus_stb_o), 32'(bus_cyc_o));
            if (start) begin
                if (bus_exp_q.size() == 0) begin
                    check("unexpected_bus", 32'(bus_cyc_o), 0);
                end else begin
                    be = bus_exp_q.pop_front();
                    check("bus_start", cyc_n, be.start);
                    check("bus_we", 32'(bus_we_o), 32'(be.we));
                    check("bus_sel", 32'(bus_sel_o), 32'(be.sel));
                    check("bus_addr", bus_addr_o, be.addr);
                    if (be.chk_dat) check("bus_dat", bus_dat_o, be.dat);
                    cur_end = be.stop;
                end
            end
            if (!bus_cyc_o && prev_cyc) check("bus_end", cyc_n, cur_end);
            if (if_ack_o || mem_ack_o || bus_fault_o) begin
                if (ack_exp_q.size() == 0) begin
                    check("unexpected_ack", {29'b0, if_ack_o, mem_ack_o, bus_fault_o}, 0);
                end else begin
                    ae = ack_exp_q.pop_front();
                    check("ack_cycle", cyc_n, ae.cyc);
                    check("if_ack", 32'(if_ack_o), 32'(ae.side == SIDE_I));
                    check("mem_ack", 32'(mem_ack_o), 32'(ae.side == SIDE_D));
                    check("bus_fault", 32'(bus_fault_o), 32'(ae.fault));
                    if (ae.side == SIDE_I) check("if_rdata", if_rdata_o, ae.data);
                    if (ae.side == SIDE_D) check("mem_rdata", mem_rdata_o, ae.data);
                end
            end
        end
        prev_cyc = bus_cyc_o;
        if (start) begin
            if (resp_q.size() > 0) begin
                cur_resp = resp_q.pop_front();
            end else begin
                cur_resp.kind = K_NONE;
                cur_resp.d    = 0;
                cur_resp.data = 32'h0;
            end
            bc = 0;
        end
        #1;
        if (rst && bus_cyc_o) begin
            bus_ack_i = (bc == cur_resp.d) && (cur_resp.kind == K_ACK || cur_resp.kind == K_ACKERR);
            bus_err_i = (bc == cur_resp.d) && (cur_resp.kind == K_ERR || cur_resp.kind == K_ACKERR);
            bus_dat_i = (bc == cur_resp.d) ? cur_resp.data : $urandom;
            bc++;
        end else begin
            bus_ack_i = 1'b0;
            bus_err_i = 1'b0;
            bus_dat_i = 32'h0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drain_check(input string tag);
        check(tag, bus_exp_q.size() + ack_exp_q.size(), 0);
        bus_exp_q.delete();
        ack_exp_q.delete();
        resp_q.delete();
    endtask

    // One data access and/or one fetch, raised together; optional flush in IDLE.
    task automatic run_pair(input bit do_m, input bit do_i, input bit iflush,
                            input logic mwe, input logic [3:0] msel,
                            input logic [31:0] maddr, input logic [31:0] mwdata,
                            input logic [31:0] iaddr,
                            input int mk, input int md, input logic [31:0] mdat,
                            input int ik, input int id, input logic [31:0] idat);
        int p, base, e, last;
        bit f, seen_m, seen_i;
        @(negedge clk);
        #1;
        p = cyc_n;
        base = p;
        last = p;
        if (do_m) begin
            e = end_bc(mk, md);
            f = is_fault(mk, md, e);
            bus_exp_q.push_back('{base + 1, base + 2 + e, mwe, msel, maddr, mwdata, 1'b1});
            resp_q.push_back('{mk, md, mdat});
            if (f) mem_model = 32'h0;
            else if (!mwe) mem_model = mdat;
            ack_exp_q.push_back('{base + 2 + e, SIDE_D, mem_model, f});
            base = base + 2 + e;
            last = base;
        end else if (iflush) begin
            base = base + 1;
        end
        if (do_i) begin
            e = end_bc(ik, id);
            f = is_fault(ik, id, e);
            bus_exp_q.push_back('{base + 1, base + 2 + e, 1'b0, 4'hF, iaddr, 32'h0, 1'b0});
            resp_q.push_back('{ik, id, idat});
            if_model = f ? 32'h0 : idat;
            ack_exp_q.push_back('{base + 2 + e, SIDE_I, if_model, f});
            last = base + 2 + e;
        end
        mem_req_i   = do_m;
        mem_we_i    = mwe;
        mem_sel_i   = msel;
        mem_addr_i  = maddr;
        mem_wdata_i = mwdata;
        if_req_i    = do_i;
        if_addr_i   = iaddr;
        flush_i     = iflush;
        seen_m = 0;
        seen_i = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (mem_ack_o) seen_m = 1;
            if (if_ack_o) seen_i = 1;
            #1;
            flush_i = 1'b0;
            if (seen_m) mem_req_i = 1'b0;
            if (seen_i) if_req_i = 1'b0;
            if (cyc_n >= last + 2) break;
        end
        mem_req_i = 1'b0;
        if_req_i  = 1'b0;
        mem_addr_i = $urandom;
        if_addr_i  = $urandom;
        @(negedge clk);
        drain_check("pair_drained");
    endtask

    // Fetch flushed during bus cycle j; no if_ack may follow.
    task automatic run_flush(input logic [31:0] iaddr, input int k, input int d,
                             input logic [31:0] dat, input int j);
        int p, e0, stop;
        bit f;
        @(negedge clk);
        #1;
        p = cyc_n;
        e0 = end_bc(k, d);
        if (j >= e0) stop = e0;
        else stop = (k != K_NONE && d <= j + TIMEOUT) ? d : j + TIMEOUT;
        f = is_fault(k, d, stop);
        bus_exp_q.push_back('{p + 1, p + 2 + stop, 1'b0, 4'hF, iaddr, 32'h0, 1'b0});
        resp_q.push_back('{k, d, dat});
        if (f) ack_exp_q.push_back('{p + 2 + stop, SIDE_N, 32'h0, 1'b1});
        if_req_i  = 1'b1;
        if_addr_i = iaddr;
        repeat (j + 1) @(negedge clk);
        #1;
        flush_i  = 1'b1;
        if_req_i = 1'b0;
        @(negedge clk);
        #1;
        flush_i = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cyc_n >= p + 3 + stop) break;
        end
        check("flush_state_idle", 32'(dbg_state), 0);
        check("flush_if_rdata_kept", if_rdata_o, if_model);
        drain_check("flush_drained");
    endtask

    task automatic run_async_reset();
        mon_en = 0;
        @(negedge clk);
        #1;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = $urandom;
        resp_q.push_back('{K_NONE, 0, 32'h0});
        repeat (2) @(negedge clk);
        check("pre_rst_cyc", 32'(bus_cyc_o), 1);
        check("pre_rst_state", 32'(dbg_state), 1);
        #3 rst = 1'b0;
        #1;
        check("arst_cyc", 32'(bus_cyc_o), 0);
        check("arst_stb", 32'(bus_stb_o), 0);
        check("arst_we", 32'(bus_we_o), 0);
        check("arst_sel", 32'(bus_sel_o), 0);
        check("arst_addr", bus_addr_o, 0);
        check("arst_dat", bus_dat_o, 0);
        check("arst_mem_rdata", mem_rdata_o, 0);
        check("arst_if_rdata", if_rdata_o, 0);
        check("arst_fault", 32'(bus_fault_o), 0);
        check("arst_state", 32'(dbg_state), 0);
        mem_req_i = 1'b0;
        bus_exp_q.delete();
        ack_exp_q.delete();
        resp_q.delete();
        mem_model = 32'h0;
        if_model  = 32'h0;
        @(negedge clk);
        #1 rst = 1'b1;
        mon_en = 1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("post_rst_mem_ack", 32'(mem_ack_o), 0);
            check("post_rst_cyc", 32'(bus_cyc_o), 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; flush_i = 1'b0;
        if_addr_i = 32'h0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0; mem_sel_i = 4'h0;
        bus_dat_i = 32'h0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cyc", 32'(bus_cyc_o), 0);
        check("rst_stb", 32'(bus_stb_o), 0);
        check("rst_we", 32'(bus_we_o), 0);
        check("rst_sel", 32'(bus_sel_o), 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_dat", bus_dat_o, 0);
        check("rst_if_rdata", if_rdata_o, 0);
        check("rst_mem_rdata", mem_rdata_o, 0);
        check("rst_if_ack", 32'(if_ack_o), 0);
        check("rst_mem_ack", 32'(mem_ack_o), 0);
        check("rst_fault", 32'(bus_fault_o), 0);
        check("rst_stall", {30'b0, stallreq_from_if_o, stallreq_from_mem_o}, 0);
        check("rst_state", 32'(dbg_state), 0);
        #1 rst = 1'b1;
        mon_en = 1;

        // single read, slave acks in the second bus cycle
        run_pair(1, 0, 0, 1'b0, 4'hF, 32'h100, 32'h0, 32'h0,
                 K_ACK, 1, 32'hDEADBEEF, K_ACK, 0, 32'h0);
        // simultaneous requests: data write goes first, then the fetch
        run_pair(1, 1, 0, 1'b1, 4'b0011, 32'h200, 32'h12345678, 32'h400,
                 K_ACK, 0, 32'h0, K_ACK, 1, 32'hCAFEF00D);
        // flush during fetch, slave acks three cycles later
        run_flush(32'h800, K_ACK, 3, 32'h55AA55AA, 0);
        // timeout on a read
        run_pair(1, 0, 0, 1'b0, 4'hF, 32'h300, 32'h0, 32'h0,
                 K_NONE, 0, 32'h0, K_ACK, 0, 32'h0);
        // simultaneous err+ack on a fetch
        run_pair(0, 1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h500,
                 K_ACK, 0, 32'h0, K_ACKERR, 1, 32'h77777777);
        // flush in IDLE delays the fetch grant by one cycle
        run_pair(0, 1, 1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h600,
                 K_ACK, 0, 32'h0, K_ACK, 0, 32'h13572468);

        for (int t = 0; t < 40; t++) begin
            bit dm, di;
            dm = 1'($urandom_range(0, 1));
            di = 1'($urandom_range(0, 1));
            if (!dm && !di) di = 1;
            run_pair(dm, di, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     4'($urandom_range(1, 15)), $urandom, $urandom, $urandom,
                     rand_kind(), int'($urandom_range(0, TIMEOUT + 1)), $urandom,
                     rand_kind(), int'($urandom_range(0, TIMEOUT + 1)), $urandom);
        end

        for (int t = 0; t < 10; t++) begin
            int k, d, e0, j;
            k  = rand_kind();
            d  = int'($urandom_range(0, TIMEOUT + 1));
            e0 = end_bc(k, d);
            j  = int'($urandom_range(0, e0));
            run_flush($urandom, k, d, $urandom, j);
        end

        run_pair(1, 0, 0, 1'b0, 4'hF, 32'h700, 32'h0, 32'h0,
                 K_ACK, 0, 32'hA5A55A5A, K_ACK, 0, 32'h0);
        run_async_reset();
        run_pair(1, 1, 0, 1'b0, 4'hF, 32'h900, 32'h0, 32'hA00,
                 K_ACK, 2, 32'h0BADF00D, K_ACK, 0, 32'h600DCAFE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
